// File: rtl/data_encryption_pkg.sv
// Shared types and constants for the encrypted-word reader.
package data_encryption_pkg;

   localparam int unsigned NSYM_DEFAULT = 5;
   localparam int unsigned SYM_W        = 2;
   localparam int unsigned ERR_CNT_W    = 8;

   typedef logic [SYM_W-1:0] sym_t;

   // 2'b10 is the only symbol that decodes to a plaintext 0
   localparam sym_t SYM_ZERO = 2'b10;
   localparam sym_t SYM_RSVD = 2'b11;

endpackage

// File: rtl/data_encryption_sym_dec.sv
// Combinational decode of one descrambled 2-bit symbol into a plaintext bit.
// Reserved-symbol flag exists only when DATA_ENCRYPTION_READER_ERR_EN is defined.
module data_encryption_sym_dec
   import data_encryption_pkg::*;
(
   input  sym_t sym,
   output logic pt_c
`ifdef DATA_ENCRYPTION_READER_ERR_EN
   ,
   output logic rsvd_c
`endif
);

   always_comb begin
      pt_c = (sym != SYM_ZERO);
   end

`ifdef DATA_ENCRYPTION_READER_ERR_EN
   always_comb begin
      rsvd_c = (sym == SYM_RSVD);
   end
`endif

endmodule

// File: rtl/data_encryption_reader.sv
// Descrambles in1 with key in2 and decodes NSYM 2-bit symbols into a registered word.
// Optional reserved-symbol flag and error counter under DATA_ENCRYPTION_READER_ERR_EN.
module data_encryption_reader
   import data_encryption_pkg::*;
#(
   parameter int unsigned NSYM = NSYM_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [2*NSYM-1:0] in1,
   input  logic [2*NSYM-1:0] in2,
   output logic [NSYM-1:0]   out,
   output logic              out_valid
`ifdef DATA_ENCRYPTION_READER_ERR_EN
   ,
   output logic                 sym_err,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam int unsigned W = 2*NSYM;

   logic [W-1:0]    x_c;
   logic [NSYM-1:0] pt_c;
`ifdef DATA_ENCRYPTION_READER_ERR_EN
   logic [NSYM-1:0] rsvd_c;
`endif

   always_comb begin
      x_c = in1 ^ in2;
   end

   // Symbol k is taken from the MSB end and lands on out[NSYM-1-k]
   for (genvar k = 0; k < NSYM; k++) begin : g_sym
      data_encryption_sym_dec u_dec (
         .sym    (x_c[W-1-2*k -: 2]),
         .pt_c   (pt_c[NSYM-1-k])
`ifdef DATA_ENCRYPTION_READER_ERR_EN
         ,
         .rsvd_c (rsvd_c[NSYM-1-k])
`endif
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out <= pt_c;
         end
      end
   end

`ifdef DATA_ENCRYPTION_READER_ERR_EN
   // Flag is held with out; counter saturates rather than wrapping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sym_err <= 1'b0;
         err_cnt <= '0;
      end else if (in_valid) begin
         sym_err <= |rsvd_c;
         if ((|rsvd_c) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_encryption_reader.sv
// Directed bench for data_encryption_reader with a symbol-level reference model.
// Checks sym_err/err_cnt too when DATA_ENCRYPTION_READER_ERR_EN is defined.
module tb_data_encryption_reader;

   localparam int unsigned NSYM = 5;
   localparam int unsigned W    = 2*NSYM;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic [W-1:0]    in1;
   logic [W-1:0]    in2;
   logic [NSYM-1:0] out;
   logic            out_valid;
`ifdef DATA_ENCRYPTION_READER_ERR_EN
   logic            sym_err;
   logic [7:0]      err_cnt;
`endif

   data_encryption_reader #(.NSYM(NSYM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in1       (in1),
      .in2       (in2),
      .out       (out),
      .out_valid (out_valid)
`ifdef DATA_ENCRYPTION_READER_ERR_EN
      ,
      .sym_err   (sym_err),
      .err_cnt   (err_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [NSYM-1:0] exp_out;
   logic            exp_valid;
   logic            exp_err;
   int              exp_cnt;

   localparam logic [W-1:0] GOLD1 = 10'b0011101100;
   localparam logic [W-1:0] GOLD2 = 10'b0010010100;

   // Symbol i counted from the LSB end gives out bit i; 2 is the lone zero symbol
   function automatic logic [NSYM-1:0] model_dec(input logic [W-1:0] c, input logic [W-1:0] k);
      int x;
      int s;
      logic [NSYM-1:0] r;
      x = int'(c ^ k);
      r = '0;
      for (int i = 0; i < NSYM; i++) begin
         s = (x >> (2*i)) % 4;
         r[i] = (s != 2);
      end
      return r;
   endfunction

   function automatic logic model_err(input logic [W-1:0] c, input logic [W-1:0] k);
      int x;
      logic e;
      x = int'(c ^ k);
      e = 1'b0;
      for (int i = 0; i < NSYM; i++) begin
         if (((x >> (2*i)) % 4) == 3) e = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // One clock: drive at negedge, update model at posedge, compare at next negedge
   task automatic step(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
      rst_n    = r;
      in_valid = v;
      in1      = a;
      in2      = b;
      @(posedge clk);
      if (!r) begin
         exp_out   = '0;
         exp_valid = 1'b0;
         exp_err   = 1'b0;
         exp_cnt   = 0;
      end else if (v) begin
         exp_out   = model_dec(a, b);
         exp_valid = 1'b1;
         exp_err   = model_err(a, b);
         if (exp_err && exp_cnt < 255) exp_cnt++;
      end else begin
         exp_valid = 1'b0;
      end
      @(negedge clk);
      chk("out", 32'(out), 32'(exp_out));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
`ifdef DATA_ENCRYPTION_READER_ERR_EN
      chk("sym_err", 32'(sym_err), 32'(exp_err));
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
   endtask

   initial begin
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_cnt   = 0;

      // Reset held for 3 cycles with in_valid high
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, GOLD1, GOLD2);
         chk("reset_out_lit", 32'(out), 32'h0);
         chk("reset_valid_lit", 32'(out_valid), 32'h0);
      end

      // Golden vector
      step(1'b1, 1'b1, GOLD1, GOLD2);
      chk("golden_lit", 32'(out), 32'b11101);
      chk("golden_valid_lit", 32'(out_valid), 32'h1);
`ifdef DATA_ENCRYPTION_READER_ERR_EN
      chk("golden_err_lit", 32'(sym_err), 32'h1);
      chk("golden_cnt_lit", 32'(err_cnt), 32'h1);
`endif

      // Zero / all-ones symbol patterns
      step(1'b1, 1'b1, 10'b1010101010, 10'h000);
      chk("zeros_lit", 32'(out), 32'b00000);
      step(1'b1, 1'b1, 10'h3FF, 10'h3FF);
      chk("ones_lit", 32'(out), 32'b11111);
`ifdef DATA_ENCRYPTION_READER_ERR_EN
      chk("ones_err_lit", 32'(sym_err), 32'h0);
`endif

      // Hold: in_valid low with random data
      step(1'b1, 1'b1, GOLD1, GOLD2);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, W'($urandom), W'($urandom));
         chk("hold_lit", 32'(out), 32'b11101);
         chk("hold_valid_lit", 32'(out_valid), 32'h0);
      end

      // Streaming back-to-back
      step(1'b1, 1'b1, GOLD1, GOLD2);
      chk("stream0_lit", 32'(out), 32'b11101);
      step(1'b1, 1'b1, 10'h000, 10'h000);
      chk("stream1_lit", 32'(out), 32'b11111);
      step(1'b1, 1'b1, 10'b1000000000, 10'h000);
      chk("stream2_lit", 32'(out), 32'b01111);
      chk("stream2_valid_lit", 32'(out_valid), 32'h1);

      // Reset mid-stream
      step(1'b1, 1'b1, GOLD1, GOLD2);
      step(1'b0, 1'b1, 10'h3FF, 10'h000);
      chk("midrst_out_lit", 32'(out), 32'h0);
      chk("midrst_valid_lit", 32'(out_valid), 32'h0);

      // Random directed mix against the model
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      end

`ifdef DATA_ENCRYPTION_READER_ERR_EN
      // Counter saturation
      step(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 260; i++) begin
         step(1'b1, 1'b1, 10'h3FF, 10'h000);
      end
      chk("sat_cnt_lit", 32'(err_cnt), 32'd255);
`endif

      step(1'b1, 1'b0, '0, '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
